// File: rtl/data_mem_responder_if.sv
// Data memory request/response bus between the core's memory stage and its responder.
`timescale 1ns/1ps

package mem_pkg;
    typedef enum logic [1:0] {
        MEM_W_SIZE_BYTE = 2'd0,
        MEM_W_SIZE_HALF = 2'd1,
        MEM_W_SIZE_WORD = 2'd2
    } mem_w_size_e;
endpackage

interface mem_if;
    logic                    valid;
    logic                    ready;
    logic                    w_en;
    logic [31:0]             addr;
    logic [31:0]             w_data;
    mem_pkg::mem_w_size_e    w_size;
    logic [31:0]             r_data;

    modport master (
        output valid, w_en, addr, w_data, w_size,
        input  ready, r_data
    );

    modport slave (
        input  valid, w_en, addr, w_data, w_size,
        output ready, r_data
    );
endinterface

// File: rtl/data_mem_responder.sv
// Word-organised data RAM responder with byte/half/word stores, word loads,
// optional wait states and misaligned/out-of-range error reporting.
`timescale 1ns/1ps

module data_mem_responder
    import mem_pkg::*;
#(
    parameter int    DEPTH_WORDS = 4096,
    parameter int    WAIT_CYCLES = 0,
    parameter string INIT_FILE   = ""
) (
    input  logic   i_clk,
    input  logic   i_rst_n,
    mem_if.slave   if_data_mem,
    output logic   o_resp_valid,
    output logic   o_err
);

    localparam int          IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [33:0] LIMIT = 34'(DEPTH_WORDS) << 2;

    typedef enum logic {S_IDLE, S_WAIT} state_e;

    state_e       state_reg, state_next;
    logic [3:0]   cnt_reg, cnt_next;
    logic         ready_reg, ready_next;
    logic         accept;
    logic         do_access;

    logic         acc_we;
    logic [31:0]  acc_addr;
    logic [31:0]  acc_wdata;
    mem_w_size_e  acc_size;

    logic             oor, mis, acc_err;
    logic [IDX_W-1:0] idx;
    logic [3:0]       be;
    logic [31:0]      lane_data;

    logic [31:0]  mem [DEPTH_WORDS];
    logic [31:0]  r_data_reg;
    logic         resp_valid_reg, err_reg;

    assign accept = if_data_mem.valid && ready_reg;

    // Zero wait states access straight from the bus; otherwise from a latched copy.
    generate
        if (WAIT_CYCLES == 0) begin : g_direct
            assign acc_we    = if_data_mem.w_en;
            assign acc_addr  = if_data_mem.addr;
            assign acc_wdata = if_data_mem.w_data;
            assign acc_size  = if_data_mem.w_size;
        end else begin : g_latched
            logic         req_we_reg;
            logic [31:0]  req_addr_reg;
            logic [31:0]  req_wdata_reg;
            mem_w_size_e  req_size_reg;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    req_we_reg    <= 1'b0;
                    req_addr_reg  <= '0;
                    req_wdata_reg <= '0;
                    req_size_reg  <= MEM_W_SIZE_BYTE;
                end else if (accept) begin
                    req_we_reg    <= if_data_mem.w_en;
                    req_addr_reg  <= if_data_mem.addr;
                    req_wdata_reg <= if_data_mem.w_data;
                    req_size_reg  <= if_data_mem.w_size;
                end
            end

            assign acc_we    = req_we_reg;
            assign acc_addr  = req_addr_reg;
            assign acc_wdata = req_wdata_reg;
            assign acc_size  = req_size_reg;
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            ready_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            ready_reg <= ready_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        do_access  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        do_access = 1'b1;
                    end else begin
                        cnt_next   = 4'(WAIT_CYCLES - 1);
                        state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_reg == 4'd0) begin
                    do_access  = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            default: state_next = S_IDLE;
        endcase
        ready_next = (state_next == S_IDLE);
    end

    always_comb begin
        be        = 4'b1111;
        lane_data = acc_wdata;
        case (acc_size)
            MEM_W_SIZE_BYTE: begin
                be        = 4'b0001 << acc_addr[1:0];
                lane_data = {4{acc_wdata[7:0]}};
            end
            MEM_W_SIZE_HALF: begin
                be        = acc_addr[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{acc_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Any size other than byte/half is treated as a full word.
    assign mis = acc_we &&
                 (((acc_size == MEM_W_SIZE_HALF) && acc_addr[0]) ||
                  ((acc_size != MEM_W_SIZE_HALF) && (acc_size != MEM_W_SIZE_BYTE) &&
                   (acc_addr[1:0] != 2'b00)));
    assign oor     = {2'b00, acc_addr} >= LIMIT;
    assign acc_err = mis || oor;
    assign idx     = acc_addr[2 +: IDX_W];

    always_ff @(posedge i_clk) begin
        if (do_access && acc_we && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][b*8 +: 8] <= lane_data[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data_reg     <= '0;
            resp_valid_reg <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            resp_valid_reg <= do_access;
            err_reg        <= do_access && acc_err;
            if (do_access && !acc_we) r_data_reg <= oor ? 32'd0 : mem[idx];
        end
    end

    assign if_data_mem.ready  = ready_reg;
    assign if_data_mem.r_data = r_data_reg;
    assign o_resp_valid       = resp_valid_reg;
    assign o_err              = err_reg;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised bench for data_mem_responder: a zero-wait 16-word instance and a
// three-wait 64-word instance, both checked against a word-array reference model.
`timescale 1ns/1ps

module tb_data_mem_responder;
    import mem_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0_n, rst1_n;
    logic rv0, er0, rv1, er1;

    mem_if m0();
    mem_if m1();

    data_mem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) dut0 (
        .i_clk(clk), .i_rst_n(rst0_n), .if_data_mem(m0.slave),
        .o_resp_valid(rv0), .o_err(er0)
    );

    data_mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(3)) dut1 (
        .i_clk(clk), .i_rst_n(rst1_n), .if_data_mem(m1.slave),
        .o_resp_valid(rv1), .o_err(er1)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] ref_mem [2][64];
    logic [31:0] ref_rd  [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int depth_of(input int d);
        return (d == 0) ? 16 : 64;
    endfunction

    function automatic int wait_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic logic get_ready(input int d);
        return (d == 0) ? m0.ready : m1.ready;
    endfunction

    function automatic logic get_rv(input int d);
        return (d == 0) ? rv0 : rv1;
    endfunction

    function automatic logic get_err(input int d);
        return (d == 0) ? er0 : er1;
    endfunction

    function automatic logic [31:0] get_rd(input int d);
        return (d == 0) ? m0.r_data : m1.r_data;
    endfunction

    // Reference: memory as plain words, lanes merged with shift/mask arithmetic.
    function automatic void model(input int d, input bit we, input logic [31:0] a,
                                  input logic [31:0] wd, input mem_w_size_e sz,
                                  output bit err, output logic [31:0] rd);
        bit          oor, mis;
        int          sh, wi;
        logic [31:0] w;
        oor = longint'(a) >= longint'(depth_of(d) * 4);
        mis = we && ((sz == MEM_W_SIZE_HALF && (a % 2) != 0) ||
                     (sz == MEM_W_SIZE_WORD && (a % 4) != 0));
        err = oor || mis;
        sh  = 8 * int'(a % 4);
        wi  = int'(a >> 2);
        if (!we) begin
            rd = oor ? 32'd0 : ref_mem[d][wi];
            ref_rd[d] = rd;
        end else begin
            rd = ref_rd[d];
            if (!err) begin
                w = ref_mem[d][wi];
                case (sz)
                    MEM_W_SIZE_BYTE: w = (w & ~(32'hFF << sh))   | ({24'd0, wd[7:0]}  << sh);
                    MEM_W_SIZE_HALF: w = (w & ~(32'hFFFF << sh)) | ({16'd0, wd[15:0]} << sh);
                    default:         w = wd;
                endcase
                ref_mem[d][wi] = w;
            end
        end
    endfunction

    task automatic set_req(input int d, input bit v, input bit we, input logic [31:0] a,
                           input logic [31:0] wd, input mem_w_size_e sz);
        if (d == 0) begin
            m0.valid = v; m0.w_en = we; m0.addr = a; m0.w_data = wd; m0.w_size = sz;
        end else begin
            m1.valid = v; m1.w_en = we; m1.addr = a; m1.w_data = wd; m1.w_size = sz;
        end
    endtask

    function automatic mem_w_size_e rand_size();
        return mem_w_size_e'($urandom_range(0, 2));
    endfunction

    function automatic logic [31:0] rand_addr(input int d);
        int lim;
        int r;
        lim = depth_of(d) * 4;
        r   = int'($urandom_range(0, 9));
        if (r < 8)       return 32'($urandom_range(0, lim - 1));
        else if (r == 8) return 32'($urandom_range(lim, lim + 63));
        else             return $urandom;
    endfunction

    // One isolated request: wait for ready, accept, scramble the bus, await the response.
    task automatic xact(input int d, input bit we, input logic [31:0] a, input logic [31:0] wd,
                        input mem_w_size_e sz, input string tag);
        bit          e;
        logic [31:0] rd;
        int          n;
        model(d, we, a, wd, sz, e, rd);
        @(negedge clk);
        set_req(d, 1'b1, we, a, wd, sz);
        n = 0;
        while (!get_ready(d) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, get_ready(d), 1'b1);
        @(posedge clk);
        #1 set_req(d, 1'b0, ~we, $urandom, $urandom, rand_size());
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!get_rv(d) && d == 1) check({tag, "_busy"}, get_ready(d), 1'b0);
        end while (!get_rv(d) && n < 50);
        check({tag, "_resp"}, get_rv(d), 1'b1);
        check({tag, "_lat"}, n, wait_of(d) + 1);
        check({tag, "_err"}, get_err(d), e);
        check({tag, "_rdata"}, get_rd(d), rd);
        check({tag, "_rdy_back"}, get_ready(d), 1'b1);
        @(negedge clk);
        check({tag, "_pulse"}, get_rv(d), 1'b0);
        check({tag, "_err_q"}, get_err(d), 1'b0);
    endtask

    // Back-to-back traffic on the zero-wait instance, one request per cycle.
    task automatic burst0(input int n);
        bit          e_q [$];
        logic [31:0] r_q [$];
        bit          e, we;
        logic [31:0] rd, a, wd;
        mem_w_size_e sz;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check("burst_resp", rv0, 1'b1);
                check("burst_err", er0, e_q.pop_front());
                check("burst_rdata", m0.r_data, r_q.pop_front());
            end
            check("burst_ready", m0.ready, 1'b1);
            if (i == 0) begin
                we = 1'b1; a = 32'h10; wd = 32'hDEADBEEF; sz = MEM_W_SIZE_WORD;
            end else if (i == 1) begin
                we = 1'b0; a = 32'h10; wd = $urandom; sz = rand_size();
            end else begin
                we = 1'($urandom_range(0, 1)); a = rand_addr(0); wd = $urandom; sz = rand_size();
            end
            model(0, we, a, wd, sz, e, rd);
            e_q.push_back(e);
            r_q.push_back(rd);
            set_req(0, 1'b1, we, a, wd, sz);
        end
        @(negedge clk);
        check("burst_resp", rv0, 1'b1);
        check("burst_err", er0, e_q.pop_front());
        check("burst_rdata", m0.r_data, r_q.pop_front());
        set_req(0, 1'b0, 1'b0, '0, '0, MEM_W_SIZE_BYTE);
        @(negedge clk);
        check("burst_idle", rv0, 1'b0);
    endtask

    initial begin
        bit          ea, eb;
        logic [31:0] rda, rdb, wd;

        set_req(0, 1'b0, 1'b0, '0, '0, MEM_W_SIZE_BYTE);
        set_req(1, 1'b0, 1'b0, '0, '0, MEM_W_SIZE_BYTE);
        ref_rd[0] = '0;
        ref_rd[1] = '0;
        rst0_n = 1'b0;
        rst1_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_ready", get_ready(d), 1'b0);
            check("rst_rdata", get_rd(d), 32'd0);
            check("rst_resp", get_rv(d), 1'b0);
            check("rst_err", get_err(d), 1'b0);
        end
        rst0_n = 1'b1;
        rst1_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst0", m0.ready, 1'b1);
        check("ready_after_rst1", m1.ready, 1'b1);

        for (int w = 0; w < 16; w++) xact(0, 1'b1, 32'(w * 4), $urandom, MEM_W_SIZE_WORD, "init0");
        for (int w = 0; w < 64; w++) xact(1, 1'b1, 32'(w * 4), $urandom, MEM_W_SIZE_WORD, "init1");

        // Lane merging on a known word
        xact(0, 1'b1, 32'h20, 32'h11223344, MEM_W_SIZE_WORD, "pre");
        xact(0, 1'b1, 32'h22, 32'h000000AA, MEM_W_SIZE_BYTE, "st_b");
        xact(0, 1'b0, 32'h20, $urandom, rand_size(), "ld_b");
        check("byte_merge", m0.r_data, 32'h11AA3344);
        xact(0, 1'b1, 32'h20, 32'h0000BBCC, MEM_W_SIZE_HALF, "st_h");
        xact(0, 1'b0, 32'h20, $urandom, rand_size(), "ld_h");
        check("half_merge", m0.r_data, 32'h11AABBCC);

        // Misaligned stores leave the word alone
        xact(0, 1'b1, 32'h21, 32'h0000FFFF, MEM_W_SIZE_HALF, "mis_h");
        xact(0, 1'b1, 32'h22, 32'hFFFFFFFF, MEM_W_SIZE_WORD, "mis_w");
        xact(0, 1'b0, 32'h20, $urandom, rand_size(), "ld_mis");
        check("mis_unchanged", m0.r_data, 32'h11AABBCC);

        // Out of range on the 16-word instance
        xact(0, 1'b0, 32'h40, $urandom, rand_size(), "oor_ld");
        check("oor_ld_zero", m0.r_data, 32'd0);
        xact(0, 1'b1, 32'h40, 32'hCAFEF00D, MEM_W_SIZE_WORD, "oor_st");
        xact(0, 1'b0, 32'h0, $urandom, rand_size(), "oor_w0");

        burst0(40);

        for (int i = 0; i < 25; i++)
            xact(0, 1'($urandom_range(0, 1)), rand_addr(0), $urandom, rand_size(), "rnd0");
        for (int i = 0; i < 30; i++)
            xact(1, 1'($urandom_range(0, 1)), rand_addr(1), $urandom, rand_size(), "rnd1");

        // Held valid with a new request: second one is taken when ready returns
        model(1, 1'b0, 32'h8, '0, MEM_W_SIZE_WORD, ea, rda);
        model(1, 1'b0, 32'hC4, '0, MEM_W_SIZE_WORD, eb, rdb);
        @(negedge clk);
        set_req(1, 1'b1, 1'b0, 32'h8, '0, MEM_W_SIZE_WORD);
        check("b2b_ready_a", m1.ready, 1'b1);
        @(posedge clk);
        #1 set_req(1, 1'b1, 1'b0, 32'hC4, '0, MEM_W_SIZE_WORD);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("b2b_busy", m1.ready, 1'b0);
            check("b2b_noresp", rv1, 1'b0);
        end
        @(negedge clk);
        check("b2b_resp_a", rv1, 1'b1);
        check("b2b_rd_a", m1.r_data, rda);
        check("b2b_ready_back", m1.ready, 1'b1);
        @(posedge clk);
        #1 set_req(1, 1'b0, 1'b0, '0, '0, MEM_W_SIZE_BYTE);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("b2b_noresp_b", rv1, 1'b0);
        end
        @(negedge clk);
        check("b2b_resp_b", rv1, 1'b1);
        check("b2b_err_b", er1, eb);
        check("b2b_rd_b", m1.r_data, rdb);

        // Reset while a store is pending drops it
        wd = ~ref_mem[1][5];
        @(negedge clk);
        set_req(1, 1'b1, 1'b1, 32'h14, wd, MEM_W_SIZE_WORD);
        check("rstw_ready", m1.ready, 1'b1);
        @(posedge clk);
        #1 set_req(1, 1'b0, 1'b0, '0, '0, MEM_W_SIZE_BYTE);
        @(posedge clk);
        #3 rst1_n = 1'b0;
        #1;
        check("rstw_ready_drop", m1.ready, 1'b0);
        check("rstw_resp_drop", rv1, 1'b0);
        @(negedge clk);
        check("rstw_noresp", rv1, 1'b0);
        @(negedge clk);
        rst1_n = 1'b1;
        ref_rd[1] = '0;
        @(negedge clk);
        check("rstw_ready_up", m1.ready, 1'b1);
        check("rstw_rdata", m1.r_data, 32'd0);
        xact(1, 1'b0, 32'h14, $urandom, rand_size(), "rstw_ld");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
